aes_128_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `aes_128` encryption core among `NUM_REQ` independent requesters. It sits directly in front of the core and owns the core's `in_bus`/`key` inputs. It latches a granted request, holds the core inputs stable for a fixed settle window, captures `out_bus`, and returns the ciphertext to the granted requester over a valid/ready response channel.

---
 rtl/aes_128_arbiter.sv | 116 +++++++++++
 tb/tb_aes_128_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_128_arbiter.sv
// aes_128_arbiter: round-robin sequencer sharing one aes_128 core among NUM_REQ requesters.
// Define AES_128_ARB_STATS_EN to add the saturating op_count response counter.
module aes_128_arbiter #(
    parameter  int NUM_REQ   = 2,
    parameter  int CORE_WAIT = 2,
    localparam int IW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [128*NUM_REQ-1:0] req_data,
    input  logic [128*NUM_REQ-1:0] req_key,
    output logic [NUM_REQ-1:0]     rsp_valid,
    input  logic [NUM_REQ-1:0]     rsp_ready,
    output logic [127:0]           rsp_data,
    output logic [127:0]           core_in,
    output logic [127:0]           core_key,
    input  logic [127:0]           core_out,
    output logic                   busy,
    output logic [IW-1:0]          grant_id
`ifdef AES_128_ARB_STATS_EN
    ,
    output logic [31:0]            op_count
`endif
);
    localparam int CW = $clog2(CORE_WAIT + 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state, state_n;
    logic [IW-1:0] ptr, sel, idx, ptr_n;
    logic [CW-1:0] cnt;
    logic          found, done, rsp_hs;

    // Scan downward so the closest valid requester at or after ptr wins.
    always_comb begin
        int j;
        sel   = ptr;
        found = 1'b0;
        idx   = '0;
        j     = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j   = int'(ptr) + k;
            j   = (j >= NUM_REQ) ? j - NUM_REQ : j;
            idx = IW'(j);
            if (req_valid[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

    assign req_ready = (state == IDLE && found) ? NUM_REQ'(1) << sel : '0;
    assign done      = cnt == CW'(1);
    assign rsp_hs    = state == RESP && rsp_ready[grant_id];
    assign ptr_n     = (grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    assign busy      = state != IDLE;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = found ? WAIT : IDLE;
            WAIT:    state_n = done ? RESP : WAIT;
            RESP:    state_n = rsp_ready[grant_id] ? IDLE : RESP;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            cnt       <= '0;
            grant_id  <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            core_in   <= '0;
            core_key  <= '0;
        end else begin
            if (state == IDLE && found) begin
                core_in  <= req_data[128*sel +: 128];
                core_key <= req_key[128*sel +: 128];
                grant_id <= sel;
                cnt      <= CW'(CORE_WAIT);
            end
            if (state == WAIT)
                cnt <= cnt - 1'b1;
            // Core inputs have been stable for CORE_WAIT cycles at this edge.
            if (state == WAIT && done) begin
                rsp_data  <= core_out;
                rsp_valid <= NUM_REQ'(1) << grant_id;
            end
            if (rsp_hs) begin
                rsp_valid <= '0;
                ptr       <= ptr_n;
            end
        end
    end

`ifdef AES_128_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst)
            op_count <= '0;
        else if (rsp_hs && op_count != '1)
            op_count <= op_count + 1'b1;
    end
`endif

endmodule

// File: tb/tb_aes_128_arbiter.sv
// tb_aes_128_arbiter: scenario tasks plus a randomized run against a transaction-level model.
// A stand-in core returns FIPS-197 ciphertexts for known vectors and a keyed mix otherwise.
module tb_aes_128_arbiter;
    localparam int NUM_REQ   = 2;
    localparam int CORE_WAIT = 2;
    localparam int IW        = 1;

    localparam logic [127:0] V0_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] V0_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] V0_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] V1_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] V1_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] V1_CT  = 128'h3925841d02dc09fbdc118597196a0b32;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NUM_REQ-1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
    logic [128*NUM_REQ-1:0] req_data, req_key;
    logic [127:0]           rsp_data, core_in, core_key, core_out, core_q;
    logic                   busy;
    logic [IW-1:0]          grant_id;
`ifdef AES_128_ARB_STATS_EN
    logic [31:0]            op_count;
`endif

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [127:0] core_fn(input logic [127:0] p, input logic [127:0] k);
        if (p == V0_PT && k == V0_KEY) return V0_CT;
        if (p == V1_PT && k == V1_KEY) return V1_CT;
        return {p[63:0], p[127:64]} ^ {k[95:0], k[127:96]} ^ 128'h9e3779b97f4a7c15f39cc0605cedc834;
    endfunction

    // One register stage: core_out lags its inputs, so an early capture reads stale data.
    always @(posedge clk) core_q <= core_fn(core_in, core_key);
    assign core_out = core_q;

    aes_128_arbiter #(.NUM_REQ(NUM_REQ), .CORE_WAIT(CORE_WAIT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .req_key(req_key),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .core_in(core_in), .core_key(core_key), .core_out(core_out),
        .busy(busy), .grant_id(grant_id)
`ifdef AES_128_ARB_STATS_EN
        , .op_count(op_count)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_rsp();
        int n = 0;
        while (rsp_valid == '0 && n < 20) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = '0;
        rsp_ready = '0;
        req_data = '0;
        req_key = '0;
        step();
        step();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
        vectors++; if (rsp_valid !== '0) begin miscompares++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        vectors++; if (rsp_data !== '0) begin miscompares++; $display("FAIL reset_rsp_data: got %h expected 0", rsp_data); end
        vectors++; if (core_in !== '0 || core_key !== '0) begin miscompares++; $display("FAIL reset_core: got %h/%h expected 0/0", core_in, core_key); end
        vectors++; if (grant_id !== '0 || req_ready !== '0) begin miscompares++; $display("FAIL reset_grant: got id %0d ready %b expected 0/0", grant_id, req_ready); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        req_data[127:0] = V0_PT;
        req_key[127:0] = V0_KEY;
        req_valid = 2'b01;
        rsp_ready = '0;
        #1;
        vectors++; if (req_ready !== 2'b01) begin miscompares++; $display("FAIL single_ready: got %b expected 01", req_ready); end
        step();
        req_valid = '0;
        vectors++; if (busy !== 1'b1 || grant_id !== 1'b0) begin miscompares++; $display("FAIL single_grant: got busy %b id %0d expected 1/0", busy, grant_id); end
        vectors++; if (core_in !== V0_PT || core_key !== V0_KEY) begin miscompares++; $display("FAIL single_core: got %h/%h expected %h/%h", core_in, core_key, V0_PT, V0_KEY); end
        step();
        vectors++; if (rsp_valid !== 2'b00) begin miscompares++; $display("FAIL single_early: got %b expected 00", rsp_valid); end
        step();
        vectors++; if (rsp_valid !== 2'b01) begin miscompares++; $display("FAIL single_valid: got %b expected 01", rsp_valid); end
        vectors++; if (rsp_data !== V0_CT) begin miscompares++; $display("FAIL single_data: got %h expected %h", rsp_data, V0_CT); end
        rsp_ready = 2'b01;
        step();
        vectors++; if (rsp_valid !== 2'b00 || busy !== 1'b0) begin miscompares++; $display("FAIL single_done: got valid %b busy %b expected 00/0", rsp_valid, busy); end
        rsp_ready = '0;
    endtask

    task automatic test_contention();
        logic [NUM_REQ-1:0] exp_rdy;
        logic [127:0]       exp_ct;
        int                 g, n, last;
        req_data = {V1_PT, V0_PT};
        req_key = {V1_KEY, V0_KEY};
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        do_reset();
        last = 0;
        for (int i = 0; i < 4; i++) begin
            g = i % 2;
            exp_rdy = NUM_REQ'(1) << g;
            exp_ct = g ? V1_CT : V0_CT;
            n = 0;
            while (req_ready == '0 && n < 20) begin
                step();
                n++;
            end
            vectors++; if (req_ready !== exp_rdy) begin miscompares++; $display("FAIL contention_grant%0d: got %b expected %b", i, req_ready, exp_rdy); end
            step();
            if (i > 0) begin
                vectors++; if (cyc - last != CORE_WAIT + 2) begin miscompares++; $display("FAIL contention_spacing%0d: got %0d expected %0d", i, cyc - last, CORE_WAIT + 2); end
            end
            last = cyc;
            wait_rsp();
            vectors++; if (rsp_valid !== exp_rdy || rsp_data !== exp_ct) begin miscompares++; $display("FAIL contention_rsp%0d: got %b %h expected %b %h", i, rsp_valid, rsp_data, exp_rdy, exp_ct); end
        end
        req_valid = '0;
        step();
        rsp_ready = '0;
    endtask

    task automatic test_backpressure();
        logic [127:0] pt, key, ct;
        do_reset();
        pt = {$urandom, $urandom, $urandom, $urandom};
        key = {$urandom, $urandom, $urandom, $urandom};
        ct = core_fn(pt, key);
        req_data[127:0] = pt;
        req_key[127:0] = key;
        req_valid = 2'b01;
        rsp_ready = '0;
        step();
        req_valid = '0;
        wait_rsp();
        req_valid = 2'b11;
        rsp_ready = 2'b10;
        for (int i = 0; i < 10; i++) begin
            #1;
            vectors++; if (rsp_valid !== 2'b01 || rsp_data !== ct) begin miscompares++; $display("FAIL bp_rsp%0d: got %b %h expected 01 %h", i, rsp_valid, rsp_data, ct); end
            vectors++; if (core_in !== pt || req_ready !== '0) begin miscompares++; $display("FAIL bp_hold%0d: got %h ready %b expected %h ready 00", i, core_in, req_ready, pt); end
            step();
        end
        rsp_ready = 2'b01;
        step();
        vectors++; if (busy !== 1'b0 || rsp_valid !== '0) begin miscompares++; $display("FAIL bp_release: got busy %b valid %b expected 0/00", busy, rsp_valid); end
        vectors++; if (req_ready !== 2'b10) begin miscompares++; $display("FAIL bp_ptr: got %b expected 10", req_ready); end
        req_valid = '0;
        rsp_ready = '0;
    endtask

    task automatic test_mutation();
        int n;
        do_reset();
        req_data[127:0] = V0_PT;
        req_key[127:0] = V0_KEY;
        req_valid = 2'b01;
        rsp_ready = 2'b01;
        step();
        req_valid = '0;
        req_data[127:0] = '1;
        n = 0;
        while (rsp_valid == '0 && n < 20) begin
            vectors++; if (core_in !== V0_PT) begin miscompares++; $display("FAIL mut_core_in: got %h expected %h", core_in, V0_PT); end
            step();
            n++;
        end
        vectors++; if (rsp_valid !== 2'b01 || rsp_data !== V0_CT) begin miscompares++; $display("FAIL mut_rsp: got %b %h expected 01 %h", rsp_valid, rsp_data, V0_CT); end
        step();
        rsp_ready = '0;
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        req_data = {V1_PT, V0_PT};
        req_key = {V1_KEY, V0_KEY};
        req_valid = 2'b01;
        rsp_ready = 2'b11;
        step();
        req_valid = '0;
        wait_rsp();
        step();
        req_valid = 2'b10;
        step();
        req_valid = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        vectors++; if (busy !== 1'b0 || rsp_valid !== '0 || req_ready !== '0) begin miscompares++; $display("FAIL rmw_ctl: got busy %b valid %b ready %b expected 0/00/00", busy, rsp_valid, req_ready); end
        vectors++; if (rsp_data !== '0 || core_in !== '0 || core_key !== '0) begin miscompares++; $display("FAIL rmw_data: got %h %h %h expected zeros", rsp_data, core_in, core_key); end
        vectors++; if (grant_id !== '0) begin miscompares++; $display("FAIL rmw_grant_id: got %0d expected 0", grant_id); end
        for (int i = 0; i < 5; i++) begin
            step();
            vectors++; if (rsp_valid !== '0) begin miscompares++; $display("FAIL rmw_no_rsp%0d: got %b expected 00", i, rsp_valid); end
        end
        req_valid = 2'b11;
        #1;
        vectors++; if (req_ready !== 2'b01) begin miscompares++; $display("FAIL rmw_next_grant: got %b expected 01", req_ready); end
        req_valid = '0;
        rsp_ready = '0;
        step();
    endtask

    task automatic test_random();
        logic [NUM_REQ-1:0] exp_rdy, exp_rv;
        logic [127:0]       m_ct;
        int                 m_ptr, m_id, m_acc, m_ops, g, j;
        req_valid = '0;
        rsp_ready = '0;
        do_reset();
        m_ptr = 0; m_id = -1; m_acc = 0; m_ops = 0; m_ct = '0;
        for (int t = 0; t < 400; t++) begin
            req_valid = NUM_REQ'($urandom);
            rsp_ready = NUM_REQ'($urandom);
            for (int i = 0; i < NUM_REQ; i++) begin
                req_data[128*i +: 128] = {$urandom, $urandom, $urandom, $urandom};
                req_key[128*i +: 128] = {$urandom, $urandom, $urandom, $urandom};
            end
            #1;
            exp_rdy = '0;
            g = -1;
            if (m_id < 0) begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    j = (m_ptr + k) % NUM_REQ;
                    if (req_valid[j] && g < 0) g = j;
                end
                if (g >= 0) exp_rdy = NUM_REQ'(1) << g;
            end
            exp_rv = (m_id >= 0 && cyc >= m_acc + CORE_WAIT) ? NUM_REQ'(1) << m_id : '0;
            vectors++; if (req_ready !== exp_rdy) begin miscompares++; $display("FAIL rnd_ready t=%0d: got %b expected %b", t, req_ready, exp_rdy); end
            vectors++; if (rsp_valid !== exp_rv) begin miscompares++; $display("FAIL rnd_valid t=%0d: got %b expected %b", t, rsp_valid, exp_rv); end
            if (exp_rv != '0) begin
                vectors++; if (rsp_data !== m_ct || grant_id !== IW'(m_id)) begin miscompares++; $display("FAIL rnd_data t=%0d: got %h id %0d expected %h id %0d", t, rsp_data, grant_id, m_ct, m_id); end
            end
            if (g >= 0) begin
                m_id = g;
                m_ct = core_fn(req_data[128*g +: 128], req_key[128*g +: 128]);
                m_acc = cyc + 1;
            end else if (exp_rv != '0 && rsp_ready[m_id]) begin
                m_ptr = (m_id + 1) % NUM_REQ;
                m_id = -1;
                m_ops++;
            end
            step();
        end
`ifdef AES_128_ARB_STATS_EN
        vectors++; if (op_count !== 32'(m_ops)) begin miscompares++; $display("FAIL rnd_op_count: got %0d expected %0d", op_count, m_ops); end
`endif
        req_valid = '0;
        rsp_ready = '0;
    endtask

`ifdef AES_128_ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        vectors++; if (op_count !== 32'd0) begin miscompares++; $display("FAIL stats_init: got %0d expected 0", op_count); end
        rsp_ready = 2'b01;
        for (int i = 0; i < 5; i++) begin
            req_data[127:0] = {$urandom, $urandom, $urandom, $urandom};
            req_valid = 2'b01;
            step();
            req_valid = '0;
            wait_rsp();
            step();
        end
        vectors++; if (op_count !== 32'd5) begin miscompares++; $display("FAIL stats_count: got %0d expected 5", op_count); end
        rsp_ready = '0;
        do_reset();
        vectors++; if (op_count !== 32'd0) begin miscompares++; $display("FAIL stats_reset: got %0d expected 0", op_count); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_mutation();
        test_reset_mid_wait();
        test_random();
`ifdef AES_128_ARB_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
